// File: rtl/fwd_hazard_pkg.sv
// Shared encodings for the forwarding/hazard unit: forwarding selects and the
// mul/div tracker state.
package fwd_hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side signal bundle of fwd_hazard_unit. The pipeline (master) drives
// stage addresses and controls; the unit (slave) returns selects and stall requests.
interface fwd_hazard_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2
);
   logic [NUM_SRC*REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0]        id_src_used;
   logic                      id_md_op;
   logic [NUM_SRC*REG_AW-1:0] ex_src;
   logic [REG_AW-1:0]         ex_rd;
   logic                      ex_mem_read;
   logic                      ex_md_start;
   logic [REG_AW-1:0]         mem_rd;
   logic                      mem_reg_write;
   logic [REG_AW-1:0]         wb_rd;
   logic                      wb_reg_write;
   logic                      flush;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic                      stall;
   logic                      id_ex_bubble;
   logic                      md_busy;
   logic                      md_done;
   // Debug view of the mul/div tracker state.
   fwd_hazard_pkg::md_state_e md_state;

   modport master (
      output id_src, id_src_used, id_md_op, ex_src, ex_rd, ex_mem_read, ex_md_start,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write, flush,
      input  fwd_sel, stall, id_ex_bubble, md_busy, md_done, md_state
   );

   modport slave (
      input  id_src, id_src_used, id_md_op, ex_src, ex_rd, ex_mem_read, ex_md_start,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write, flush,
      output fwd_sel, stall, id_ex_bubble, md_busy, md_done, md_state
   );
endinterface

// File: rtl/fwd_hazard_unit_md_tracker.sv
// Tracks one in-flight multi-cycle mul/div: IDLE/BUSY FSM, remaining-cycle
// counter and captured destination register.
module md_tracker
   import fwd_hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [REG_AW-1:0] rd,
   output logic              md_busy,
   output logic              md_done,
   output logic [REG_AW-1:0] md_rd,
   output md_state_e         state
);
   localparam int CW = $clog2(MD_LAT);

   md_state_e         state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [REG_AW-1:0] rd_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MD_IDLE;
         cnt   <= '0;
         md_rd <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         md_rd <= rd_n;
      end
   end

   // Outputs depend on state only, so start may legally depend on md_busy.
   assign md_busy = (state == MD_BUSY);
   assign md_done = (state == MD_BUSY) && (cnt == '0);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rd_n    = md_rd;
      case (state)
         MD_IDLE: begin
            if (start) begin
               state_n = MD_BUSY;
               cnt_n   = CW'(MD_LAT - 1);
               rd_n    = rd;
            end
         end
         MD_BUSY: begin
            if (cnt == '0) begin
               // A start in the done cycle chains straight into a new operation.
               if (start) begin
                  cnt_n = CW'(MD_LAT - 1);
                  rd_n  = rd;
               end else begin
                  state_n = MD_IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = MD_IDLE;
      endcase
   end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use and mul/div stall generation.
// Define ZERO_REG_FWD_EN to treat register 0 as hardwired zero (never matches).
module fwd_hazard_unit
   import fwd_hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MD_LAT  = 4
) (
   input logic               clk,
   input logic               rst_n,
   fwd_hazard_unit_if.slave  hz
);
`ifdef ZERO_REG_FWD_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic                 md_busy;
   logic                 md_done;
   logic [REG_AW-1:0]    md_rd;
   md_state_e            md_state;
   logic                 load_use;
   logic                 md_dep;
   logic                 hazard;
   logic                 start_ok;
   logic [2*NUM_SRC-1:0] fwd;

   function automatic logic addr_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a == b) && !(ZERO_REG && (a == '0));
   endfunction

   // EX/MEM result is newer than MEM/WB, so it takes priority.
   always_comb begin
      fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hz.mem_reg_write && addr_hit(hz.mem_rd, hz.ex_src[i*REG_AW +: REG_AW]))
            fwd[2*i +: 2] = FWD_MEM;
         else if (hz.wb_reg_write && addr_hit(hz.wb_rd, hz.ex_src[i*REG_AW +: REG_AW]))
            fwd[2*i +: 2] = FWD_WB;
         else
            fwd[2*i +: 2] = FWD_RF;
      end
   end

   always_comb begin
      load_use = 1'b0;
      md_dep   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (hz.id_src_used[i] && addr_hit(hz.id_src[i*REG_AW +: REG_AW], hz.ex_rd))
            load_use = 1'b1;
         if (hz.id_src_used[i] && addr_hit(hz.id_src[i*REG_AW +: REG_AW], md_rd))
            md_dep = 1'b1;
      end
      // Flush kills the ID instruction, so there is nothing left to hold.
      hazard = ((hz.ex_mem_read && load_use) || (md_busy && (hz.id_md_op || md_dep)))
               && !hz.flush;
   end

   assign start_ok = hz.ex_md_start && !hazard;

   md_tracker #(
      .REG_AW (REG_AW),
      .MD_LAT (MD_LAT)
   ) u_md_tracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_ok),
      .rd      (hz.ex_rd),
      .md_busy (md_busy),
      .md_done (md_done),
      .md_rd   (md_rd),
      .state   (md_state)
   );

   assign hz.fwd_sel      = fwd;
   assign hz.stall        = hazard;
   assign hz.id_ex_bubble = hazard;
   assign hz.md_busy      = md_busy;
   assign hz.md_done      = md_done;
   assign hz.md_state     = md_state;
endmodule
